mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified byte-addressed memory between the instruction-fetch port (IF) and the data-memory port (DM, the MEM stage).
- Selects one requester at a time and sequences the memory control signals over a configurable number of wait states.
- Returns read data with a one-cycle ready pulse.
- Uses DM-first priority, with a streak limit so IF is never starved.

Parameters:
- DATA_W, 32, width of address and data; matches `INSTRUCTION_LEN.
- WAIT_CYCLES, 1, extra cycles the ACCESS state holds before the response (0..15).
- MAX_DM_STREAK, 4, maximum consecutive DM grants while IF is also pending (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr stable until if_ready.
- if_addr  in  DATA_W  IF byte address.
- if_ready  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DATA_W  fetched word.
- dm_req  in  1  DM request; held with dm_we/dm_addr/dm_wdata stable until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  DATA_W  DM byte address.
- dm_wdata  in  DATA_W  DM write data.
- dm_ready  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  DM read data; 0 for writes.
- m_addr  out  DATA_W  address to memory.
- m_wdata  out  DATA_W  write data to memory.
- m_read  out  1  memory read enable.
- m_write  out  1  memory write enable.
- m_rdata  in  DATA_W  memory read data (combinational from m_addr/m_read).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (sync rst, active-high):
  - state = IDLE; wait counter = 0; streak counter = 0; grant = none.
  - m_addr, m_wdata, m_read, m_write, if_ready, dm_ready, busy = 0.
  - if_rdata, dm_rdata = 0.
- rst overrides everything, including mid-ACCESS and RESP. An in-flight request is dropped with no ready pulse, and no write is issued if m_write has not yet pulsed. The requester must re-issue.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, latch the grant, addr, we and wdata; load wait counter = WAIT_CYCLES; go to ACCESS.
- Arbitration (IDLE only):
  - Only one port requesting: grant it.
  - Both requesting: grant DM unless streak == MAX_DM_STREAK, in which case grant IF.
- Streak counter:
  - Increment on a DM grant while if_req = 1.
  - Clear on an IF grant, or on a DM grant with if_req = 0.
  - Saturates at MAX_DM_STREAK.
- Address alignment:
  - m_addr = latched addr with bits [1:0] forced to 0 for both ports.
  - Misaligned requests are silently word-aligned.
- ACCESS outputs:
  - m_addr and m_wdata driven from latched values.
  - m_read = !we.
  - m_write = we only in the final ACCESS cycle (counter == 0): exactly one write pulse per request.
- ACCESS transitions:
  - counter != 0: decrement, stay in ACCESS.
  - counter == 0: capture m_rdata (reads only) into the granted port's rdata register, go to RESP.
- RESP:
  - Granted port's ready = 1 for exactly one cycle.
  - m_read and m_write = 0; m_addr holds.
  - Next state is IDLE unconditionally.
- Request handling after ready:
  - A requester seeing ready may keep req high for a new transaction; it is sampled in the following IDLE cycle.
  - The other port's pending request is arbitrated in that same IDLE cycle.
- Latency: req sampled in IDLE at cycle t; ACCESS occupies t+1 .. t+1+WAIT_CYCLES; ready at t+2+WAIT_CYCLES.
- Throughput: one transaction per WAIT_CYCLES+3 cycles.
- Read data holding:
  - if_rdata holds its last fetched value until the next IF read completes.
  - dm_rdata holds its last read value until the next DM read completes, and is set to 0 on DM write completion.
- Requests are not sampled outside IDLE. A req that appears and drops while busy is ignored; the protocol forbids it.
- busy = (state != IDLE).

Test Plan:
1. WAIT_CYCLES=1, memory word 0 = 0xE3A00014; if_req at cycle 0, addr 0 -> if_ready=1 exactly at cycle 3 with if_rdata=0xE3A00014; m_write never asserted; dm_ready stays 0.
2. DM write then read:
   - Stimulus: dm write 0x00002000 to addr 1024, then dm read of addr 1024.
   - Write: m_write high for exactly one cycle with m_addr=1024; dm_ready after the write with dm_rdata=0.
   - Read: dm_rdata=0x00002000.
3. Simultaneous if_req and dm_req in the same cycle, streak=0 -> DM served first; IF granted in the IDLE cycle after dm_ready; IF ready WAIT_CYCLES+3 cycles after dm_ready.
4. Starvation, MAX_DM_STREAK=4: dm_req and if_req held continuously -> grant order DM, DM, DM, DM, IF, DM...; streak returns to 0 after the IF grant.
5. Misaligned DM write to addr 1030 with data 0xFFFFFF85 -> m_addr=1028 during ACCESS; a subsequent read of 1028 returns 0xFFFFFF85.
6. Reset mid-transaction: rst pulsed during ACCESS of a DM write with WAIT_CYCLES=3, before the final cycle -> next cycle state IDLE, busy=0, m_write never pulsed, no dm_ready; a re-issued request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between instruction fetch (IF) and data memory (DM) ports.
// DM wins ties until its streak limit is reached; each access runs WAIT_CYCLES+1 ACCESS cycles.
module mem_arbiter #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned WAIT_CYCLES   = 1,
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [DATA_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [DATA_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_read,
   output logic              m_write,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   localparam logic [3:0] WaitInit  = 4'(WAIT_CYCLES);
   localparam logic [3:0] MaxStreak = 4'(MAX_DM_STREAK);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [3:0]        wait_q, wait_d;
   logic [3:0]        streak_q, streak_d;
   logic              grant_if_q, grant_if_d;
   logic              grant_dm_q, grant_dm_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              pick_dm;

   // IF only overrides a pending DM request once DM has used up its streak.
   assign pick_dm = dm_req && !(if_req && (streak_q == MaxStreak));

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      streak_d   = streak_q;
      grant_if_d = grant_if_q;
      grant_dm_d = grant_dm_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (if_req || dm_req) begin
               grant_dm_d = pick_dm;
               grant_if_d = !pick_dm;
               wait_d     = WaitInit;
               state_d    = StAccess;
               if (pick_dm) begin
                  we_d    = dm_we;
                  addr_d  = dm_addr;
                  wdata_d = dm_wdata;
                  if (!if_req) begin
                     streak_d = '0;
                  end else if (streak_q != MaxStreak) begin
                     streak_d = streak_q + 4'd1;
                  end
               end else begin
                  we_d     = 1'b0;
                  addr_d   = if_addr;
                  wdata_d  = '0;
                  streak_d = '0;
               end
            end
         end
         StAccess: begin
            if (wait_q != '0) begin
               wait_d = wait_q - 4'd1;
            end else begin
               state_d = StResp;
               if (grant_dm_q) begin
                  dm_rdata_d = we_q ? '0 : m_rdata;
               end else begin
                  if_rdata_d = m_rdata;
               end
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wait_q     <= '0;
         streak_q   <= '0;
         grant_if_q <= 1'b0;
         grant_dm_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         streak_q   <= streak_d;
         grant_if_q <= grant_if_d;
         grant_dm_q <= grant_dm_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Misaligned requests are silently word-aligned.
   assign m_addr   = {addr_q[DATA_W-1:2], 2'b00};
   assign m_wdata  = wdata_q;
   assign m_read   = (state_q == StAccess) && !we_q;
   assign m_write  = (state_q == StAccess) && we_q && (wait_q == '0);
   assign if_ready = (state_q == StResp) && grant_if_q;
   assign dm_ready = (state_q == StResp) && grant_dm_q;
   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a main instance (WAIT_CYCLES=1) with a memory model,
// plus a WAIT_CYCLES=3 instance used for the mid-access reset scenario.
module tb_mem_arbiter;

   typedef struct {
      bit          is_dm;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic        if_ready, dm_ready, m_read, m_write, busy;
   logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata, m_rdata;

   logic        r_rst = 1'b1;
   logic        r_if_req = 1'b0, r_dm_req = 1'b0, r_dm_we = 1'b0;
   logic [31:0] r_if_addr = '0, r_dm_addr = '0, r_dm_wdata = '0, r_m_rdata = '0;
   logic        r_if_ready, r_dm_ready, r_m_read, r_m_write, r_busy;
   logic [31:0] r_if_rdata, r_dm_rdata, r_m_addr, r_m_wdata;

   logic [31:0] mem [0:1023];
   int          cyc = 0;
   int          n_tests = 0, n_fail = 0;
   int          wr_count = 0, r_wr_count = 0;
   logic [31:0] wr_addr = '0, r_wr_addr = '0;
   exp_t        sb[$];
   exp_t        r_sb[$];

   mem_arbiter #(.DATA_W(32), .WAIT_CYCLES(1), .MAX_DM_STREAK(4)) u_dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write), .m_rdata(m_rdata), .busy(busy)
   );

   mem_arbiter #(.DATA_W(32), .WAIT_CYCLES(3), .MAX_DM_STREAK(4)) u_dut3 (
      .clk(clk), .rst(r_rst), .if_req(r_if_req), .if_addr(r_if_addr), .if_ready(r_if_ready),
      .if_rdata(r_if_rdata), .dm_req(r_dm_req), .dm_we(r_dm_we), .dm_addr(r_dm_addr),
      .dm_wdata(r_dm_wdata), .dm_ready(r_dm_ready), .dm_rdata(r_dm_rdata),
      .m_addr(r_m_addr), .m_wdata(r_m_wdata), .m_read(r_m_read), .m_write(r_m_write),
      .m_rdata(r_m_rdata), .busy(r_busy)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the clock edge; word 0 preloaded in reset.
   assign m_rdata = m_read ? mem[m_addr[11:2]] : 32'h0;
   always @(posedge clk) begin
      if (rst) mem[0] <= 32'hE3A00014;
      else if (m_write) mem[m_addr[11:2]] <= m_wdata;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per ready pulse, independent of the stimulus.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (m_write) begin
         wr_count++;
         wr_addr = m_addr;
      end
      if (r_m_write) begin
         r_wr_count++;
         r_wr_addr = r_m_addr;
      end
      if (if_ready || dm_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_ready", {30'd0, if_ready, dm_ready}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ready_port", {30'd0, if_ready, dm_ready}, e.is_dm ? 32'd1 : 32'd2);
            chk("rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
            if (e.cyc >= 0) chk("ready_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (r_dm_ready || r_if_ready) begin
         if (r_sb.size() == 0) begin
            chk("r_unexpected_ready", {30'd0, r_if_ready, r_dm_ready}, 32'd0);
         end else begin
            e = r_sb.pop_front();
            chk("r_rdata", r_dm_rdata, e.data);
            chk("r_ready_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic push(input bit is_dm, input logic [31:0] data, input int c);
      exp_t e;
      e.is_dm = is_dm;
      e.data  = data;
      e.cyc   = c;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input bit is_dm);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(is_dm ? dm_ready : if_ready) && k < 100);
      if (!(is_dm ? dm_ready : if_ready)) chk(is_dm ? "dm_timeout" : "if_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Request held across n back-to-back transactions, dropped after the last ready.
   task automatic dm_burst(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input int n);
      dm_we = we;
      dm_addr = a;
      dm_wdata = d;
      dm_req = 1'b1;
      for (int i = 0; i < n; i++) wait_ready(1'b1);
      dm_req = 1'b0;
   endtask

   task automatic if_burst(input logic [31:0] a, input int n);
      if_addr = a;
      if_req = 1'b1;
      for (int i = 0; i < n; i++) wait_ready(1'b0);
      if_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
      $fatal(1);
   end

   initial begin
      int c0;
      int w0;
      int k;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      r_rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_ctrl", {28'd0, m_read, m_write, if_ready, dm_ready}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      @(posedge clk);
      #1;

      // 1: single IF fetch, ready exactly 3 cycles after the request.
      c0 = cyc;
      w0 = wr_count;
      push(1'b0, 32'hE3A00014, c0 + 3);
      if_burst(32'd0, 1);
      chk("if_no_write", 32'(wr_count - w0), 32'd0);

      // 2: DM write then read back.
      c0 = cyc;
      w0 = wr_count;
      push(1'b1, 32'd0, c0 + 3);
      dm_burst(1'b1, 32'd1024, 32'h00002000, 1);
      chk("wr_pulses", 32'(wr_count - w0), 32'd1);
      chk("wr_addr", wr_addr, 32'd1024);
      push(1'b1, 32'h00002000, cyc + 3);
      dm_burst(1'b0, 32'd1024, 32'd0, 1);

      // 3: simultaneous requests: DM first, IF ready WAIT_CYCLES+3 after dm_ready.
      c0 = cyc;
      push(1'b1, 32'h00002000, c0 + 3);
      push(1'b0, 32'hE3A00014, c0 + 7);
      fork
         dm_burst(1'b0, 32'd1024, 32'd0, 1);
         if_burst(32'd0, 1);
      join

      // 4: both held: four DM grants, one IF, four DM (streak cleared), then IF.
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         push((i != 4) && (i != 9), (i == 4 || i == 9) ? 32'hE3A00014 : 32'h00002000,
              c0 + 3 + 4 * i);
      end
      fork
         dm_burst(1'b0, 32'd1024, 32'd0, 8);
         if_burst(32'd0, 2);
      join

      // 5: misaligned write is word-aligned, then read back from the aligned address.
      w0 = wr_count;
      push(1'b1, 32'd0, cyc + 3);
      dm_burst(1'b1, 32'd1030, 32'hFFFFFF85, 1);
      chk("mis_wr_pulses", 32'(wr_count - w0), 32'd1);
      chk("mis_wr_addr", wr_addr, 32'd1028);
      push(1'b1, 32'hFFFFFF85, cyc + 3);
      dm_burst(1'b0, 32'd1028, 32'd0, 1);

      // 6: reset during ACCESS of a write on the WAIT_CYCLES=3 instance.
      r_dm_we = 1'b1;
      r_dm_addr = 32'd8;
      r_dm_wdata = 32'h55;
      r_dm_req = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("r_busy_access", {31'd0, r_busy}, 32'd1);
      @(posedge clk);
      #1;
      r_rst = 1'b1;
      r_dm_req = 1'b0;
      @(posedge clk);
      #1;
      r_rst = 1'b0;
      @(negedge clk);
      chk("r_busy_after_rst", {31'd0, r_busy}, 32'd0);
      repeat (8) @(negedge clk);
      chk("r_no_write", 32'(r_wr_count), 32'd0);
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e.is_dm = 1'b1;
         e.data = 32'd0;
         e.cyc = cyc + 5;
         r_sb.push_back(e);
      end
      r_dm_req = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!r_dm_ready && k < 100);
      if (!r_dm_ready) chk("r_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      r_dm_req = 1'b0;
      chk("r_wr_pulses", 32'(r_wr_count), 32'd1);
      chk("r_wr_addr", r_wr_addr, 32'd8);

      repeat (10) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("r_sb_drained", 32'(r_sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
